// File: rtl/seg_scan_scheduler_if.sv
// seg_scan_scheduler_if: display-word handshake and display outputs (i_valid/o_ready/i_data/i_dp in, o_seg/o_dp/o_an/o_frame out)
interface seg_scan_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    i_valid;
  logic                    o_ready;
  logic [4*NUM_DIGITS-1:0] i_data;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [6:0]              o_seg;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_an;
  logic                    o_frame;
  modport master (
    output i_valid, i_data, i_dp,
    input  o_ready, o_seg, o_dp, o_an, o_frame
  );
  modport slave (
    input  i_valid, i_data, i_dp,
    output o_ready, o_seg, o_dp, o_an, o_frame
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: blanked 7-seg digit multiplexer with frame-aligned shadow commit (ports i_clk, i_rst, bus.slave; optional LEADING_ZERO_BLANK_EN)
module seg_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_CNT      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic             i_clk,
  input logic             i_rst,
  seg_scan_scheduler_if.slave bus
);
  localparam int MAXC = DIV_CNT > BLANK_CYCLES ? DIV_CNT : BLANK_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = 4 * NUM_DIGITS;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {BLANK, SHOW} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         act_q, act_d, sh_q, sh_d;
  logic [NUM_DIGITS-1:0] adp_q, adp_d, sdp_q, sdp_d, an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            nib;
  logic                  pend_q, pend_d, dp_q, dp_d, frame_q;
  logic                  last, commit, fire, lz;
  always_comb begin
    last    = state_q == SHOW ? cnt_q == CW'(DIV_CNT - 1) : cnt_q == CW'(BLANK_CYCLES - 1);
    commit  = state_q == SHOW && last && idx_q == IW'(NUM_DIGITS - 1);
    fire    = bus.i_valid && !pend_q;
    state_d = last ? (state_q == SHOW ? BLANK : SHOW) : state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    idx_d   = state_q == SHOW && last ? (commit ? '0 : idx_q + 1'b1) : idx_q;
    act_d   = commit && pend_q ? sh_q : act_q;
    adp_d   = commit && pend_q ? sdp_q : adp_q;
    sh_d    = fire ? bus.i_data : sh_q;
    sdp_d   = fire ? bus.i_dp : sdp_q;
    pend_d  = fire || (pend_q && !commit);
    // The lit pattern is taken from act_q: act only changes on the commit edge, which always enters BLANK.
    nib     = act_q[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz      = idx_d != '0 && (act_q >> (4*idx_d)) == '0 && !adp_q[idx_d];
`else
    lz      = 1'b0;
`endif
    an_d    = state_d == SHOW ? NUM_DIGITS'(1) << idx_d : '0;
    seg_d   = state_d == SHOW && !lz ? HEX[nib] : '0;
    dp_d    = state_d == SHOW && !lz && adp_q[idx_d];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      adp_q   <= '0;
      sh_q    <= '0;
      sdp_q   <= '0;
      pend_q  <= 1'b0;
      an_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      sh_q    <= sh_d;
      sdp_q   <= sdp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= commit;
    end
  end
  assign bus.o_ready = !pend_q;
  assign bus.o_an    = an_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_frame = frame_q;
endmodule
